// File: rtl/asconp_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package asconp_pkg;

    localparam int ROUNDS_MAX_DEF = 12;
    localparam int ROUNDS_TOTAL   = 12;

    typedef logic [63:0] word_t;

    typedef struct packed {
        word_t x0;
        word_t x1;
        word_t x2;
        word_t x3;
        word_t x4;
    } state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_e;

    // Round constant for round index idx of the 12-round schedule.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [3:0] hi;
        hi = 4'd15 - idx;
        return {hi, idx};
    endfunction

    function automatic word_t ror(input word_t w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

endpackage

// File: rtl/asconp_round.sv
// One Ascon round: constant add, bitsliced S-box, linear layer; bypassed when en=0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module asconp_round
    import asconp_pkg::*;
(
    input  state_t     s_in,
    input  logic [3:0] idx,
    input  logic       en,
    output state_t     s_out
);

    state_t c_add;
    state_t s_box;
    state_t lin;
    word_t  b0, b1, b2, b3, b4;
    word_t  t0, t1, t2, t3, t4;

    always_comb begin
        c_add    = s_in;
        c_add.x2 = s_in.x2 ^ {56'd0, round_const(idx)};
    end

    // Bitsliced 5-bit S-box applied to all 64 columns at once.
    always_comb begin
        b0 = c_add.x0 ^ c_add.x4;
        b1 = c_add.x1;
        b2 = c_add.x2 ^ c_add.x1;
        b3 = c_add.x3;
        b4 = c_add.x4 ^ c_add.x3;

        t0 = ~b0 & b1;
        t1 = ~b1 & b2;
        t2 = ~b2 & b3;
        t3 = ~b3 & b4;
        t4 = ~b4 & b0;

        b0 = b0 ^ t1;
        b1 = b1 ^ t2;
        b2 = b2 ^ t3;
        b3 = b3 ^ t4;
        b4 = b4 ^ t0;

        s_box.x1 = b1 ^ b0;
        s_box.x0 = b0 ^ b4;
        s_box.x3 = b3 ^ b2;
        s_box.x2 = ~b2;
        s_box.x4 = b4;
    end

    always_comb begin
        lin.x0 = s_box.x0 ^ ror(s_box.x0, 19) ^ ror(s_box.x0, 28);
        lin.x1 = s_box.x1 ^ ror(s_box.x1, 61) ^ ror(s_box.x1, 39);
        lin.x2 = s_box.x2 ^ ror(s_box.x2, 1)  ^ ror(s_box.x2, 6);
        lin.x3 = s_box.x3 ^ ror(s_box.x3, 10) ^ ror(s_box.x3, 17);
        lin.x4 = s_box.x4 ^ ror(s_box.x4, 7)  ^ ror(s_box.x4, 41);
    end

    assign s_out = en ? lin : s_in;

endmodule

// File: rtl/asconp_iter.sv
// Iterative Ascon-p permutation, UROL rounds per cycle, nr = min(rounds_i, ROUNDS_MAX).
// Latency: result valid ceil(nr/UROL) cycles after the accept edge (0 allowed).
// Backpressure: result held in DONE until out_ready_i; no new request accepted until IDLE.
module asconp_iter
    import asconp_pkg::*;
#(
    parameter int UROL       = 1,
    parameter int ROUNDS_MAX = ROUNDS_MAX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  rounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy_o
);

    fsm_e       fsm_q, fsm_d;
    state_t     st_q, st_d;
    logic [3:0] r_q, r_d;
    logic [3:0] nr;
    logic [4:0] r_step;
    state_t     chain [UROL+1];

    assign chain[0] = st_q;

    // Slot k works on round index r+k; slots past the last round pass through.
    for (genvar k = 0; k < UROL; k++) begin : g_round
        logic [4:0] slot;
        assign slot = {1'b0, r_q} + 5'(k);

        asconp_round u_round (
            .s_in  (chain[k]),
            .idx   (slot[3:0]),
            .en    (slot < 5'(ROUNDS_TOTAL)),
            .s_out (chain[k+1])
        );
    end

    assign nr     = (rounds_i > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds_i;
    assign r_step = {1'b0, r_q} + 5'(UROL);

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        r_d   = r_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    st_d  = {x0_i, x1_i, x2_i, x3_i, x4_i};
                    r_d   = 4'(ROUNDS_TOTAL) - nr;
                    fsm_d = (nr == 4'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                st_d = chain[UROL];
                if (r_step >= 5'(ROUNDS_TOTAL)) begin
                    r_d   = 4'(ROUNDS_TOTAL);
                    fsm_d = ST_DONE;
                end else begin
                    r_d = r_step[3:0];
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q <= ST_IDLE;
            st_q  <= '0;
            r_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            r_q   <= r_d;
        end
    end

    assign in_ready_o  = (fsm_q == ST_IDLE);
    assign out_valid_o = (fsm_q == ST_DONE);
    assign busy_o      = (fsm_q != ST_IDLE);

    assign x0_o = st_q.x0;
    assign x1_o = st_q.x1;
    assign x2_o = st_q.x2;
    assign x3_o = st_q.x3;
    assign x4_o = st_q.x4;

endmodule

// File: tb/tb_asconp_iter.sv
// Bench for asconp_iter: two instances (UROL=1 and UROL=4) checked every cycle
// against a table-driven Ascon reference model kept in the bench.
module tb_asconp_iter;

    typedef logic [4:0][63:0] wst_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic [3:0] rounds    [2];
    wst_t       xi        [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       busy      [2];
    wst_t       xo        [2];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        asconp_iter #(
            .UROL       (g == 0 ? 1 : 4),
            .ROUNDS_MAX (12)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .rounds_i    (rounds[g]),
            .x0_i        (xi[g][0]),
            .x1_i        (xi[g][1]),
            .x2_i        (xi[g][2]),
            .x3_i        (xi[g][3]),
            .x4_i        (xi[g][4]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .x0_o        (xo[g][0]),
            .x1_o        (xo[g][1]),
            .x2_o        (xo[g][2]),
            .x3_o        (xo[g][3]),
            .x4_o        (xo[g][4]),
            .busy_o      (busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    // One round using the S-box lookup table column by column (x0 is the column MSB).
    function automatic wst_t ref_round(input wst_t s, input int i);
        wst_t       t;
        logic [4:0] v;
        logic [4:0] o;
        s[2] = s[2] ^ 64'((15 - i) * 16 + i);
        for (int c = 0; c < 64; c++) begin
            v = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
            o = SBOX[v];
            for (int w = 0; w < 5; w++) t[w][c] = o[4-w];
        end
        s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
        s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        return s;
    endfunction

    function automatic wst_t ref_range(input wst_t s, input int lo, input int hi);
        for (int i = lo; i < hi; i++) s = ref_round(s, i);
        return s;
    endfunction

    function automatic int clampnr(input int nr);
        return (nr > 12) ? 12 : nr;
    endfunction

    function automatic wst_t ref_perm(input wst_t s, input int nr);
        return ref_range(s, 12 - clampnr(nr), 12);
    endfunction

    function automatic int urol_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int latency(input int d, input int nr);
        return (clampnr(nr) + urol_of(d) - 1) / urol_of(d);
    endfunction

    function automatic wst_t rnd_state();
        wst_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Cycle-level expectation: phase 0 idle, 1 permuting, 2 result presented.
    int   m_phase [2];
    int   m_lo    [2];
    int   m_cur   [2];
    int   m_nr    [2];
    bit   m_on    [2];
    wst_t m_s0    [2];
    wst_t m_exp   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_on[d]    = 1'b0;
            m_exp[d]   = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d] === 1'b1) begin
                m_on[d]    = 1'b1;
                m_phase[d] = 0;
                m_exp[d]   = '0;
            end else if (m_on[d]) begin
                case (m_phase[d])
                    0: if (in_valid[d]) begin
                        m_nr[d]    = clampnr(int'(rounds[d]));
                        m_s0[d]    = xi[d];
                        m_lo[d]    = 12 - m_nr[d];
                        m_cur[d]   = m_lo[d];
                        m_exp[d]   = xi[d];
                        m_phase[d] = (m_nr[d] == 0) ? 2 : 1;
                    end
                    1: begin
                        m_cur[d] = m_cur[d] + urol_of(d);
                        if (m_cur[d] >= 12) begin
                            m_cur[d]   = 12;
                            m_phase[d] = 2;
                        end
                        m_exp[d] = ref_range(m_s0[d], m_lo[d], m_cur[d]);
                    end
                    default: if (out_ready[d]) m_phase[d] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_on[d]) begin
                chk($sformatf("d%0d in_ready", d), 320'(in_ready[d]), 320'(m_phase[d] == 0));
                chk($sformatf("d%0d busy", d), 320'(busy[d]), 320'(m_phase[d] != 0));
                chk($sformatf("d%0d out_valid", d), 320'(out_valid[d]), 320'(m_phase[d] == 2));
                chk($sformatf("d%0d state", d), xo[d], m_exp[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input wst_t s, input logic [3:0] nr);
        int b;
        b = 0;
        while (!in_ready[d] && b < 100) begin
            tick();
            b++;
        end
        chk($sformatf("d%0d ready for request", d), 320'(in_ready[d]), 320'(1));
        xi[d]       = s;
        rounds[d]   = nr;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int cyc);
        cyc = 0;
        while (!out_valid[d] && cyc < 100) begin
            tick();
            cyc++;
        end
        chk($sformatf("d%0d out_valid reached", d), 320'(out_valid[d]), 320'(1));
    endtask

    task automatic run_one(input int d, input wst_t s, input logic [3:0] nr, input string tag);
        int cyc;
        send(d, s, nr);
        wait_out(d, cyc);
        chk($sformatf("d%0d %s latency", d, tag), 320'(cyc), 320'(latency(d, int'(nr))));
        chk($sformatf("d%0d %s result", d, tag), xo[d], ref_perm(s, int'(nr)));
    endtask

    wst_t cst;
    wst_t s_a;
    wst_t pin;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int d;
        int nr;
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            rounds[k]    = 4'd0;
            xi[k]        = '0;
        end
        for (int w = 0; w < 5; w++) cst[w] = 64'h0123456789abcdef;

        // Hand-computed pins of the reference model: one round (index 11) of the zero state.
        pin = ref_round('0, 11);
        chk("pin round11 x2", 320'(pin[2]), 320'(64'h53ffffffffffff90));
        chk("pin round11 x3", 320'(pin[3]), 320'(64'h12e580000000004b));
        chk("pin round11 x4", 320'(pin[4]), 320'(64'h0));
        chk("pin identity nr0", ref_perm(cst, 0), cst);

        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d reset in_ready", k), 320'(in_ready[k]), 320'(1));
            chk($sformatf("d%0d reset busy", k), 320'(busy[k]), 320'(0));
            chk($sformatf("d%0d reset state", k), xo[k], 320'(0));
        end

        // Full p12 on UROL=1, p6 on UROL=4, zero rounds and clamped rounds on both.
        run_one(0, rnd_state(), 4'd12, "p12");
        run_one(1, rnd_state(), 4'd6, "p6");
        for (int k = 0; k < 2; k++) begin
            run_one(k, cst, 4'd0, "p0");
            chk($sformatf("d%0d p0 literal", k), xo[k], cst);
            run_one(k, rnd_state(), 4'd15, "p15");
        end

        // Back-pressure in DONE with a competing request that must be ignored.
        out_ready[0] = 1'b0;
        s_a = rnd_state();
        send(0, s_a, 4'd8);
        wait_out(0, cyc);
        xi[0]       = rnd_state();
        rounds[0]   = 4'd12;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall hold", xo[0], ref_perm(s_a, 8));
            chk("stall in_ready", 320'(in_ready[0]), 320'(0));
            chk("stall out_valid", 320'(out_valid[0]), 320'(1));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("release idle", 320'(in_ready[0]), 320'(1));
        chk("release out_valid", 320'(out_valid[0]), 320'(0));

        // Reset in RUN cycle 3 of p12 discards the permutation.
        send(0, rnd_state(), 4'd12);
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("abort in_ready", 320'(in_ready[0]), 320'(1));
        chk("abort busy", 320'(busy[0]), 320'(0));
        chk("abort state", xo[0], 320'(0));
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("abort no output", 320'(out_valid[0]), 320'(0));
        end
        run_one(0, rnd_state(), 4'd8, "p8 after abort");

        // Back-to-back requests: one IDLE cycle between handshake and next accept.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                run_one(k, rnd_state(), 4'(6 + 2 * (i % 4)), "b2b");
                tick();
                chk($sformatf("d%0d b2b gap idle", k), 320'(in_ready[k]), 320'(1));
            end
        end

        // Randomized requests with random consumer stalls.
        for (int i = 0; i < 30; i++) begin
            d  = int'($urandom_range(1, 0));
            nr = int'($urandom_range(15, 0));
            s_a = rnd_state();
            out_ready[d] = 1'b0;
            send(d, s_a, 4'(nr));
            wait_out(d, cyc);
            chk($sformatf("d%0d rnd latency", d), 320'(cyc), 320'(latency(d, nr)));
            chk($sformatf("d%0d rnd result", d), xo[d], ref_perm(s_a, nr));
            repeat ($urandom_range(3, 0)) tick();
            out_ready[d] = 1'b1;
            tick();
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/asconp_iter.md
ASCONP_ITER -- requirements
Module: asconp_iter

Interface
REQ-001 Parameter UROL, default 1, rounds per clock cycle; legal values 1, 2, 3, 4, 6.
REQ-002 Parameter ROUNDS_MAX, default 12, largest round count accepted.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 in_valid_i  input  1  state and round count on inputs are valid.
REQ-006 in_ready_o  output  1  block can accept a new permutation request.
REQ-007 rounds_i  input  4  number of rounds nr to apply (Ascon-p6/p8/p12 typical).
REQ-008 x0_i..x4_i  input  64 each  input state words.
REQ-009 out_valid_o  output  1  permuted state on x*_o is valid.
REQ-010 out_ready_i  input  1  consumer accepts the result.
REQ-011 x0_o..x4_o  output  64 each  permuted state words.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-015 On a rising edge with in_valid_i&in_ready_o, the block SHALL load x0_i..x4_i into the state register, latch nr = min(rounds_i, ROUNDS_MAX), and set round index r = 12 - nr.
REQ-016 After an accept, the FSM SHALL go to RUN if nr > 0, or directly to DONE if nr = 0 (state returned unchanged).
REQ-017 Each RUN cycle SHALL apply UROL chained rounds. Slot k uses round index r+k, and the slot is enabled only if r+k < 12.
REQ-018 A disabled slot SHALL pass its input through unchanged, so that nr need not be a multiple of UROL.
REQ-019 Each round SHALL be: constant addition on x2 with ((15-i)<<4)|i for round index i, then the 5-bit Ascon S-box bitsliced over 64 columns, then the Ascon linear layer (x0: 19,28; x1: 61,39; x2: 1,6; x3: 10,17; x4: 7,41 right rotations XORed with the word).
REQ-020 r SHALL advance by UROL per RUN cycle. When r+UROL >= 12, the next state SHALL be DONE.
REQ-021 Latency: for an accept at edge E0, out_valid_o SHALL be high in the cycle after edge E0+N, where N = ceil(nr/UROL). N = 0 is allowed.
REQ-022 In DONE, out_valid_o SHALL be 1 and x*_o SHALL hold stable until out_ready_i is sampled high. The FSM then returns to IDLE.
REQ-023 out_valid_o SHALL be 0 outside DONE.
REQ-024 x*_o SHALL always reflect the state register, including during RUN.
REQ-025 in_valid_i SHALL be ignored while in_ready_o = 0. No request is queued.
REQ-026 rounds_i values above ROUNDS_MAX SHALL be clamped to ROUNDS_MAX.

Reset
REQ-027 While rst_i is high at a rising edge, the FSM SHALL go to IDLE, r SHALL be set to 0, the state register SHALL be cleared, and out_valid_o SHALL go to 0.
REQ-028 Reset SHALL override an accept, a RUN step, or an output handshake occurring on the same edge. A permutation in progress SHALL be discarded with no output.
REQ-029 In the first cycle after reset: in_ready_o = 1, busy_o = 0, x*_o = 0.

Structure
REQ-030 A shared package asconp_pkg SHALL hold:
- the 5x64 state typedef;
- the ROUNDS_MAX default;
- the round-constant function;
- the FSM state enum.
REQ-031 One sub-module asconp_round SHALL implement one round (constant add, S-box, linear layer) plus an enable bypass. It SHALL be instantiated UROL times in a chain.
REQ-032 The round datapath SHALL be purely combinational between state-register outputs and inputs. There SHALL be no other pipeline registers.

Verification
REQ-033 UROL=1, rounds_i=12, random state, out_ready_i=1 -> out_valid_o rises exactly 12 cycles after the accept edge; output equals the golden Ascon-p12 model.
REQ-034 UROL=4, rounds_i=6 -> N=2. The second cycle applies only 2 rounds (indices 10, 11). Output equals the golden Ascon-p6, out_valid_o at E0+2.
REQ-035 rounds_i=0, state all 0x0123456789abcdef -> out_valid_o high after edge E0 with the state unchanged. rounds_i=15 -> behaves as 12 rounds.
REQ-036 Back-pressure: out_ready_i held 0 for 5 cycles in DONE -> x*_o stable, in_ready_o = 0, a new in_valid_i is ignored. out_ready_i=1 -> IDLE next cycle.
REQ-037 rst_i pulsed for 1 cycle at RUN cycle 3 of p12 -> IDLE, outputs 0, no out_valid_o. A following p8 request completes correctly.
REQ-038 Back-to-back requests with out_ready_i=1 -> each result matches the model. The gap is 1 IDLE cycle between out handshake and next accept.
